// File: rtl/execute_memory_pkg.sv
// Shared definitions for the EX/MEM pipeline register: default data width and
// the bundle of control bits carried from execute to memory.
package execute_memory_pkg;

    localparam int DATA_W_DEFAULT = 16;

    typedef struct packed {
        logic wbs;
        logic mm;
        logic wm;
        logic ni;
        logic wce;
        logic wme1;
        logic wme2;
    } ex_mem_ctrl_t;

    localparam int CTRL_W = $bits(ex_mem_ctrl_t);

endpackage

// File: rtl/execute_memory_register_pipe_reg.sv
// Generic pipeline register stage: synchronous active-low reset, flush clears
// the stage to a bubble, stall holds it. Priority is reset > flush > stall.
module pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             stall,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: state is updated with non-blocking assignments so every stage of
    // the pipeline samples its neighbours' pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/execute_memory_register.sv
// EX/MEM pipeline register: carries the control bundle, ALU result and store
// data across one clock, with stall (hold) and flush (bubble) controls.
module execute_memory_register
    import execute_memory_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall = 1'b0,
    input  logic              flush = 1'b0,
    input  logic              wbs_in,
    input  logic              mm_in,
    input  logic              wm_in,
    input  logic              ni_in,
    input  logic              wce_in,
    input  logic              wme1_in,
    input  logic              wme2_in,
    input  logic [DATA_W-1:0] ALUresult_in,
    input  logic [DATA_W-1:0] memData_in,
    output logic              wbs_out,
    output logic              mm_out,
    output logic              wm_out,
    output logic              ni_out,
    output logic              wce_out,
    output logic              wme1_out,
    output logic              wme2_out,
    output logic [DATA_W-1:0] ALUresult_out,
    output logic [DATA_W-1:0] memData_out
);

    ex_mem_ctrl_t ctrl_d;
    ex_mem_ctrl_t ctrl_q;

    assign ctrl_d = '{
        wbs:  wbs_in,
        mm:   mm_in,
        wm:   wm_in,
        ni:   ni_in,
        wce:  wce_in,
        wme1: wme1_in,
        wme2: wme2_in
    };

    pipe_reg #(.WIDTH(CTRL_W)) u_ctrl_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .stall (stall),
        .d     (ctrl_d),
        .q     (ctrl_q)
    );

    pipe_reg #(.WIDTH(DATA_W)) u_alu_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .stall (stall),
        .d     (ALUresult_in),
        .q     (ALUresult_out)
    );

    pipe_reg #(.WIDTH(DATA_W)) u_mem_data_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .stall (stall),
        .d     (memData_in),
        .q     (memData_out)
    );

    // Pure wiring from the flop outputs; no logic between register and port.
    assign wbs_out  = ctrl_q.wbs;
    assign mm_out   = ctrl_q.mm;
    assign wm_out   = ctrl_q.wm;
    assign ni_out   = ctrl_q.ni;
    assign wce_out  = ctrl_q.wce;
    assign wme1_out = ctrl_q.wme1;
    assign wme2_out = ctrl_q.wme2;

endmodule

// File: tb/tb_execute_memory_register.sv
// Scoreboard bench for the EX/MEM register: stimulus pushes the expected
// post-edge contents, a monitor pops and compares after every rising edge.
module tb_execute_memory_register;

    localparam int DW = 16;
    localparam int VW = 7 + 2 * DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall;
    logic          flush;
    logic          wbs_in, mm_in, wm_in, ni_in, wce_in, wme1_in, wme2_in;
    logic [DW-1:0] ALUresult_in, memData_in;
    logic          wbs_out, mm_out, wm_out, ni_out, wce_out, wme1_out, wme2_out;
    logic [DW-1:0] ALUresult_out, memData_out;

    int tests_run = 0;
    int tests_failed = 0;

    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] model;
    bit            model_valid = 1'b0;
    bit            stim_done = 1'b0;

    execute_memory_register #(.DATA_W(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .flush         (flush),
        .wbs_in        (wbs_in),
        .mm_in         (mm_in),
        .wm_in         (wm_in),
        .ni_in         (ni_in),
        .wce_in        (wce_in),
        .wme1_in       (wme1_in),
        .wme2_in       (wme2_in),
        .ALUresult_in  (ALUresult_in),
        .memData_in    (memData_in),
        .wbs_out       (wbs_out),
        .mm_out        (mm_out),
        .wm_out        (wm_out),
        .ni_out        (ni_out),
        .wce_out       (wce_out),
        .wme1_out      (wme1_out),
        .wme2_out      (wme2_out),
        .ALUresult_out (ALUresult_out),
        .memData_out   (memData_out)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] dut_vec();
        return {wbs_out, mm_out, wm_out, ni_out, wce_out, wme1_out, wme2_out,
                ALUresult_out, memData_out};
    endfunction

    task automatic check(input string name, input logic [VW-1:0] got,
                         input logic [VW-1:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Drives one cycle of inputs at the falling edge; ctrl is
    // {wbs, mm, wm, ni, wce, wme1, wme2}.
    task automatic cycle(input bit r, input bit f, input bit s,
                         input logic [6:0] ctrl, input logic [DW-1:0] alu,
                         input logic [DW-1:0] mdat);
        logic [VW-1:0] in_vec;
        logic [VW-1:0] nxt;
        @(negedge clk);
        rst_n = r;
        flush = f;
        stall = s;
        {wbs_in, mm_in, wm_in, ni_in, wce_in, wme1_in, wme2_in} = ctrl;
        ALUresult_in = alu;
        memData_in   = mdat;
        in_vec = {ctrl, alu, mdat};
        // Expected register contents after the coming edge.
        if (!r)      nxt = '0;
        else if (f)  nxt = '0;
        else if (s)  nxt = model;
        else         nxt = in_vec;
        #1;
        if (model_valid) check("between_edges_hold", dut_vec(), model);
        model = nxt;
        model_valid = 1'b1;
        exp_q.push_back(nxt);
    endtask

    // Monitor: every edge presents a new register value.
    initial begin
        logic [VW-1:0] want;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                check("after_edge", dut_vec(), want);
            end
        end
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        {wbs_in, mm_in, wm_in, ni_in, wce_in, wme1_in, wme2_in} = '1;
        ALUresult_in = '1; memData_in = '1;

        // Reset with every input high.
        cycle(0, 0, 0, 7'h7F, 16'hFFFF, 16'hFFFF);
        // Load, reload, control independence.
        cycle(1, 0, 0, 7'b1111_000, 16'h1234, 16'hABCD);
        cycle(1, 0, 0, 7'b0000_000, 16'h4A81, 16'h7755);
        cycle(1, 0, 0, 7'b0000_101, 16'h8001, 16'h00FF);
        cycle(1, 0, 0, 7'b1010_110, 16'h0000, 16'hFFFF);
        // Stall holds for three edges, then releases.
        cycle(1, 0, 0, 7'b1111_000, 16'h1234, 16'hABCD);
        for (int i = 0; i < 3; i++) cycle(1, 0, 1, 7'b0101_010, 16'h4A81, 16'h7755);
        cycle(1, 0, 0, 7'b0101_010, 16'h4A81, 16'h7755);
        // Flush wins over stall.
        cycle(1, 1, 1, 7'h7F, 16'hFFFF, 16'hFFFF);
        cycle(1, 0, 0, 7'h7F, 16'hC3C3, 16'h3C3C);
        // Reset dropped between edges: no change until the edge, then clear.
        cycle(0, 0, 0, 7'h7F, 16'h5555, 16'hAAAA);
        cycle(1, 0, 1, 7'h55, 16'h1111, 16'h2222);
        cycle(1, 0, 0, 7'h2A, 16'h9876, 16'h5432);
        // Reset beats flush and stall.
        cycle(0, 1, 1, 7'h7F, 16'hFFFF, 16'hFFFF);

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(19) != 0), ($urandom_range(7) == 0),
                  ($urandom_range(3) == 0), 7'($urandom),
                  16'($urandom), 16'($urandom));
        end
        stim_done = 1'b1;
    end

    initial begin
        int budget;
        wait (stim_done);
        budget = 10;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            #2;
            budget--;
        end
        if (exp_q.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
